// File: rtl/sd_pkg.sv
// Shared SD host definitions: card-type codes, CMD indices, reader FSM encoding.
package sd_pkg;

    typedef enum logic [1:0] {
        CARD_UNKNOWN = 2'd0,
        CARD_SDV1    = 2'd1,
        CARD_SDV2    = 2'd2,
        CARD_SDHCV2  = 2'd3
    } card_type_t;

    localparam logic [5:0] CMD_SEND_STATUS  = 6'd13;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RX_DATA = 3'd3,
        ST_RX_CRC  = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } rd_state_t;

    // Block-addressed cards take the sector number; byte-addressed cards take sector*512.
    function automatic logic [31:0] sector_to_arg(input logic [1:0] ctype,
                                                  input logic [31:0] sector);
        return (ctype == CARD_SDHCV2) ? sector : {sector[22:0], 9'd0};
    endfunction

endpackage

// File: rtl/crc16_d1.sv
// Serial CRC16 (x^16+x^12+x^5+1), one data bit per enable, cleared to zero.
module crc16_d1 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    logic fb;

    assign fb = din ^ crc[15];

    always_ff @(posedge clk) begin
        if (!rstn || clr)
            crc <= 16'h0000;
        else if (en)
            crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
endmodule

// File: rtl/sd_sector_receiver.sv
// CMD17 single-block read host: issues the command, samples DAT0 on sdclk rising
// edges, streams indexed bytes and reports CRC status.
//
// state      | meaning
// IDLE       | ready for StartRead
// SEND       | one-cycle CMD17 request to the CMD engine
// WAIT       | waiting for CMD response and DAT0 start bit concurrently
// RX_DATA    | receiving 4096 payload bits
// RX_CRC     | receiving 16 CRC bits plus end bit
// DONE       | block complete, wait for CMD engine idle
// ERROR      | CMD or start-bit failure, wait for CMD engine idle
module sd_sector_receiver
    import sd_pkg::*;
#(
    parameter int          START_TIMEOUT = 1000000,
    parameter logic [15:0] CMD_PRECNT    = 16'd96
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sdclk,
    input  logic        sddat0,
    input  logic [1:0]  theCard_type,
    input  logic [31:0] readSectorAddress,
    input  logic        StartRead,
    output logic        isAbleToLaunch,
    output logic        outen,
    output logic [8:0]  outaddr,
    output logic [7:0]  outbyte,
    output logic        readBlockFinish,
    output logic        crcOk,
    output logic        readError,
    output logic        start,
    output logic [15:0] precnt,
    output logic [5:0]  cmd,
    output logic [31:0] arg,
    input  logic        busy,
    input  logic        done,
    input  logic        timeout,
    input  logic        syntaxe,
    input  logic [31:0] resparg
);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    rd_state_t   state, state_nxt;
    logic        sdclkl, rise, start_hit, cmd_err, tmr_tc;
    logic [TW-1:0] tmr;
    logic [12:0] bit_cnt;
    logic [4:0]  crc_cnt;
    logic [7:0]  shreg;
    logic [15:0] rxcrc, crc_val;
    logic [31:0] addr_q;
    logic        unused_resp;

    assign unused_resp = ^resparg;
    assign rise      = ~sdclkl & sdclk;
    assign start_hit = rise & ~sddat0;
    assign cmd_err   = done & (timeout | syntaxe);
    assign tmr_tc    = rise & sddat0 & (tmr == TW'(1));

    crc16_d1 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == ST_WAIT),
        .en   ((state == ST_RX_DATA) && rise),
        .din  (sddat0),
        .crc  (crc_val)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (StartRead && !busy) state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cmd_err)        state_nxt = ST_ERROR;
                else if (start_hit) state_nxt = ST_RX_DATA;
                else if (tmr_tc)    state_nxt = ST_ERROR;
            end
            ST_RX_DATA: if (rise && bit_cnt == 13'd4095) state_nxt = ST_RX_CRC;
            ST_RX_CRC:  if (rise && crc_cnt == 5'd16)    state_nxt = ST_DONE;
            ST_DONE,
            ST_ERROR:   if (!busy) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        isAbleToLaunch = rstn && (state == ST_IDLE);
        start  = 1'b0;
        cmd    = 6'd0;
        precnt = 16'd0;
        arg    = 32'd0;
        if (rstn && state == ST_SEND) begin
            start  = 1'b1;
            cmd    = CMD_READ_SINGLE;
            precnt = CMD_PRECNT;
            arg    = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sdclkl          <= 1'b0;
            tmr             <= '0;
            bit_cnt         <= 13'd0;
            crc_cnt         <= 5'd0;
            shreg           <= 8'd0;
            rxcrc           <= 16'd0;
            addr_q          <= 32'd0;
            outen           <= 1'b0;
            outaddr         <= 9'd0;
            outbyte         <= 8'd0;
            readBlockFinish <= 1'b0;
            crcOk           <= 1'b0;
            readError       <= 1'b0;
        end else begin
            sdclkl          <= sdclk;
            outen           <= 1'b0;
            readBlockFinish <= 1'b0;
            case (state)
                ST_IDLE: if (StartRead && !busy) begin
                    addr_q    <= sector_to_arg(theCard_type, readSectorAddress);
                    crcOk     <= 1'b0;
                    readError <= 1'b0;
                end
                ST_SEND: tmr <= TW'(START_TIMEOUT);
                ST_WAIT: begin
                    bit_cnt <= 13'd0;
                    crc_cnt <= 5'd0;
                    if (rise) tmr <= tmr - TW'(1);
                    if (cmd_err || (!start_hit && tmr_tc)) begin
                        readError       <= 1'b1;
                        readBlockFinish <= 1'b1;
                    end
                end
                ST_RX_DATA: if (rise) begin
                    shreg   <= {shreg[6:0], sddat0};
                    bit_cnt <= bit_cnt + 13'd1;
                    if (bit_cnt[2:0] == 3'd7) begin
                        outen   <= 1'b1;
                        outbyte <= {shreg[6:0], sddat0};
                        outaddr <= bit_cnt[11:3];
                    end
                end
                // the 17th edge is the end bit; its value is not checked
                ST_RX_CRC: if (rise) begin
                    if (crc_cnt == 5'd16) begin
                        crcOk           <= (rxcrc == crc_val);
                        readBlockFinish <= 1'b1;
                    end else begin
                        rxcrc   <= {rxcrc[14:0], sddat0};
                        crc_cnt <= crc_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_receiver.sv
// Self-checking bench for sd_sector_receiver: CMD engine model plus byte scoreboard.
module tb_sd_sector_receiver;
    import sd_pkg::*;

    logic        clk = 1'b0, rstn = 1'b0, sdclk = 1'b1, sddat0 = 1'b1;
    logic [1:0]  theCard_type = 2'd0;
    logic [31:0] readSectorAddress = 32'd0;
    logic        StartRead = 1'b0;
    logic        isAbleToLaunch, outen, readBlockFinish, crcOk, readError, start;
    logic [8:0]  outaddr;
    logic [7:0]  outbyte;
    logic [15:0] precnt;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        busy = 1'b0, done = 1'b0, timeout = 1'b0, syntaxe = 1'b0;
    logic [31:0] resparg = 32'd0;

    sd_sector_receiver #(.START_TIMEOUT(100), .CMD_PRECNT(16'd96)) dut (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0(sddat0),
        .theCard_type(theCard_type), .readSectorAddress(readSectorAddress),
        .StartRead(StartRead), .isAbleToLaunch(isAbleToLaunch), .outen(outen),
        .outaddr(outaddr), .outbyte(outbyte), .readBlockFinish(readBlockFinish),
        .crcOk(crcOk), .readError(readError), .start(start), .precnt(precnt),
        .cmd(cmd), .arg(arg), .busy(busy), .done(done), .timeout(timeout),
        .syntaxe(syntaxe), .resparg(resparg)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // CMD engine: busy for eng_delay cycles after start, then a one-cycle done.
    int          eng_cnt = 0, eng_delay = 6, n_start = 0;
    logic        eng_to = 1'b0;
    logic [5:0]  got_cmd;
    logic [31:0] got_arg;
    logic [15:0] got_pre;

    always @(negedge clk) begin
        if (start) begin
            n_start++;
            got_cmd = cmd; got_arg = arg; got_pre = precnt;
            busy = 1'b1; eng_cnt = eng_delay; done = 1'b0; timeout = 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                done = 1'b1; timeout = eng_to; busy = 1'b0;
            end
        end else begin
            done = 1'b0; timeout = 1'b0;
        end
    end

    // Scoreboard of {index, byte}; monitor also counts outen and finish pulses.
    logic [16:0] exp_q[$];
    int          n_outen = 0, n_fin = 0;

    always @(negedge clk) begin
        if (outen) begin
            n_outen++;
            if (exp_q.size() == 0) chk("outen_unexpected", 32'(exp_q.size()), 32'd1);
            else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("outaddr", 32'(outaddr), 32'(e[16:8]));
                chk("outbyte", 32'(outbyte), 32'(e[7:0]));
            end
        end
        if (readBlockFinish) n_fin++;
    end

    logic [7:0] pay[512];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sd_bit(input logic b);
        @(negedge clk); sdclk = 1'b0; sddat0 = b;
        @(negedge clk); sdclk = 1'b1;
    endtask

    task automatic launch(input logic [1:0] ctype, input logic [31:0] addr,
                          input logic [31:0] exp_arg, input string tag);
        int s0;
        s0 = n_start;
        @(negedge clk);
        chk({tag, "_able"}, 32'(isAbleToLaunch), 32'd1);
        theCard_type = ctype; readSectorAddress = addr; StartRead = 1'b1;
        @(negedge clk);
        StartRead = 1'b0;
        for (int i = 0; i < 10 && n_start == s0; i++) @(negedge clk);
        chk({tag, "_start"}, 32'(n_start - s0), 32'd1);
        chk({tag, "_cmd"}, 32'(got_cmd), 32'd17);
        chk({tag, "_arg"}, got_arg, exp_arg);
        chk({tag, "_precnt"}, 32'(got_pre), 32'd96);
        chk({tag, "_err_clr"}, 32'(readError), 32'd0);
    endtask

    task automatic send_block(input logic corrupt, input logic use_const,
                              input logic [15:0] cconst, input int nbytes);
        logic [15:0] c, tx;
        logic [8:0]  idx;
        c = 16'h0000;
        sd_bit(1'b0);
        for (int i = 0; i < nbytes; i++) begin
            idx = 9'(i);
            exp_q.push_back({idx, pay[i]});
            for (int b = 7; b >= 0; b--) begin
                c = crc_step(c, pay[i][b]);
                sd_bit(pay[i][b]);
            end
        end
        if (nbytes == 512) begin
            tx = use_const ? cconst : c;
            if (corrupt) tx[0] = ~tx[0];
            for (int b = 15; b >= 0; b--) sd_bit(tx[b]);
            sd_bit(1'b1);
        end
    endtask

    task automatic wait_finish(input string tag, input int f0);
        for (int i = 0; i < 100 && n_fin == f0; i++) @(negedge clk);
        chk({tag, "_finish"}, 32'(n_fin - f0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        wait_clks(3);
        chk("rst_able", 32'(isAbleToLaunch), 32'd0);
        chk("rst_outen", 32'(outen), 32'd0);
        chk("rst_finish", 32'(readBlockFinish), 32'd0);
        chk("rst_crcok", 32'(crcOk), 32'd0);
        chk("rst_err", 32'(readError), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        rstn = 1'b1;
        wait_clks(1);
        chk("idle_able", 32'(isAbleToLaunch), 32'd1);

        // 1: SDHCv2, block addressing, good CRC
        for (int i = 0; i < 512; i++) pay[i] = 8'(i);
        n_outen = 0; f0 = n_fin;
        launch(2'd3, 32'd5, 32'd5, "t1");
        wait_clks(8);
        send_block(1'b0, 1'b0, 16'h0, 512);
        wait_finish("t1", f0);
        chk("t1_crcok", 32'(crcOk), 32'd1);
        chk("t1_err", 32'(readError), 32'd0);
        chk("t1_count", 32'(n_outen), 32'd512);
        chk("t1_qempty", 32'(exp_q.size()), 32'd0);
        wait_clks(3);

        // 2: SDv2 byte addressing, corrupted CRC
        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        n_outen = 0; f0 = n_fin;
        launch(2'd2, 32'd3, 32'h600, "t2");
        wait_clks(8);
        send_block(1'b1, 1'b0, 16'h0, 512);
        wait_finish("t2", f0);
        chk("t2_crcok", 32'(crcOk), 32'd0);
        chk("t2_err", 32'(readError), 32'd0);
        chk("t2_count", 32'(n_outen), 32'd512);
        wait_clks(3);

        // 3: CMD engine reports timeout
        eng_to = 1'b1; n_outen = 0; f0 = n_fin;
        launch(2'd1, 32'd7, 32'hE00, "t3");
        wait_finish("t3", f0);
        chk("t3_err", 32'(readError), 32'd1);
        chk("t3_crcok", 32'(crcOk), 32'd0);
        chk("t3_count", 32'(n_outen), 32'd0);
        wait_clks(3);
        chk("t3_idle", 32'(isAbleToLaunch), 32'd1);
        eng_to = 1'b0;

        // 4: no start bit; error on exactly the 100th edge
        f0 = n_fin;
        launch(2'd3, 32'd9, 32'd9, "t4");
        wait_clks(10);
        repeat (99) sd_bit(1'b1);
        wait_clks(2);
        chk("t4_err_at99", 32'(readError), 32'd0);
        chk("t4_fin_at99", 32'(n_fin - f0), 32'd0);
        sd_bit(1'b1);
        wait_finish("t4", f0);
        chk("t4_err_at100", 32'(readError), 32'd1);
        wait_clks(3);

        // 5: all-0xFF payload, start bit before CMD done, reference CRC 0x7FA1
        for (int i = 0; i < 512; i++) pay[i] = 8'hFF;
        eng_delay = 200; n_outen = 0; f0 = n_fin;
        launch(2'd3, 32'd12, 32'd12, "t5");
        send_block(1'b0, 1'b1, 16'h7FA1, 512);
        wait_finish("t5", f0);
        chk("t5_crcok", 32'(crcOk), 32'd1);
        chk("t5_err", 32'(readError), 32'd0);
        chk("t5_count", 32'(n_outen), 32'd512);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        eng_delay = 6;
        wait_clks(3);

        // 6: reset at byte 200, then a clean block
        for (int i = 0; i < 512; i++) pay[i] = 8'(i * 7 + 3);
        n_outen = 0; f0 = n_fin;
        launch(2'd3, 32'd20, 32'd20, "t6");
        wait_clks(8);
        send_block(1'b0, 1'b0, 16'h0, 200);
        wait_clks(2);
        chk("t6_partial", 32'(n_outen), 32'd200);
        rstn = 1'b0;
        wait_clks(2);
        chk("t6_rst_able", 32'(isAbleToLaunch), 32'd0);
        chk("t6_rst_outen", 32'(outen), 32'd0);
        chk("t6_rst_crcok", 32'(crcOk), 32'd0);
        chk("t6_rst_err", 32'(readError), 32'd0);
        rstn = 1'b1;
        wait_clks(2);
        chk("t6_idle", 32'(isAbleToLaunch), 32'd1);
        chk("t6_no_finish", 32'(n_fin - f0), 32'd0);
        chk("t6_no_outen", 32'(n_outen), 32'd200);
        exp_q.delete();
        n_outen = 0; f0 = n_fin;
        launch(2'd3, 32'd21, 32'd21, "t6b");
        wait_clks(8);
        send_block(1'b0, 1'b0, 16'h0, 512);
        wait_finish("t6b", f0);
        chk("t6b_crcok", 32'(crcOk), 32'd1);
        chk("t6b_count", 32'(n_outen), 32'd512);
        wait_clks(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
